trap_ctrl: RTL
==============

# trap_ctrl

Trap and interrupt controller for the core pipeline; sits directly upstream of the CSR file and drives its control-write port. It detects ecall, mret, external and timer interrupts, and stalls the pipeline. It then writes mstatus/mepc through the CSR control path in one cycle and redirects the PC to mtvec or mepc.

## Interface
- RESET_CAUSE, 32'h0, reset value of cause_o
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- irq_ext_i  in  1  external interrupt request, level
- irq_timer_i  in  1  timer interrupt request, level
- ecall_i  in  1  ecall in execute stage, valid with inst_valid_i
- mret_i  in  1  mret in execute stage, valid with inst_valid_i
- inst_valid_i  in  1  execute stage holds a real instruction
- inst_addr_i  in  32  PC of execute-stage instruction
- bus_busy_i  in  1  load/store transaction outstanding
- mstatus_i, mepc_i, mtvec_i, mie_i  in  32 each  current CSR values from CSR file
- hold_o  out  1  stall whole pipeline
- jump_o  out  1  one-cycle PC redirect + flush
- jump_addr_o  out  32  redirect target
- csr_we_o  out  1  CSR write enable
- csr_ctrl_we_o  out  1  select control-write values in CSR file
- mstatus_o, mepc_o, mie_o  out  32 each  values for control write
- cause_o  out  32  cause of last trap taken (reserved for mcause)

## Operation
- States: IDLE, WAIT_BUS, WRITE_CSR, JUMP; 2-bit encoded register.
- Event detection is in IDLE only and qualified by inst_valid_i=1. Priority: mret > ecall > ext irq > timer irq.
- Interrupt enabling:
  - ext irq is enabled when mstatus_i[3] (MIE)=1 and mie_i[11] (MEIE)=1.
  - timer irq is enabled when MIE=1 and mie_i[7] (MTIE)=1.
  - ecall and mret are unconditional.
- On an event in IDLE:
  - latch kind (trap/mret) and epc=inst_addr_i.
  - latch cause: ecall 32'd11, ext 32'h8000000B, timer 32'h80000007.
  - mret does not latch a cause.
  - the execute-stage instruction is not committed.
- IDLE→WAIT_BUS if bus_busy_i=1, else IDLE→WRITE_CSR.
- WAIT_BUS: stay while bus_busy_i=1; →WRITE_CSR when 0.
- WRITE_CSR (1 cycle): csr_we_o=csr_ctrl_we_o=1, mie_o=mie_i; →JUMP.
  - trap: mstatus_o = mstatus_i with bit7 (MPIE)←bit3, bit3←0, other bits unchanged; mepc_o=epc.
  - mret: mstatus_o = mstatus_i with bit3←bit7, bit7←1; mepc_o=mepc_i.
- JUMP (1 cycle): jump_o=1; →IDLE.
  - trap: jump_addr_o={mtvec_i[31:2],2'b00}.
  - mret: jump_addr_o=mepc_i.
- cause_o updates to the latched cause on entering WRITE_CSR for traps only.
- Events arriving while not in IDLE are ignored. Level interrupts stay pending and are re-evaluated in IDLE. ecall/mret are not lost because the pipeline is held.
- Outside WRITE_CSR, csr_we_o=csr_ctrl_we_o=0 and mstatus_o/mepc_o/mie_o=0. Outside JUMP, jump_o=0 and jump_addr_o=0.

## Timing
- hold_o is combinational: 1 in the IDLE cycle an accepted event is detected, and 1 in WAIT_BUS, WRITE_CSR and JUMP.
- Nominal latency, event in cycle N with bus idle:
  - WRITE_CSR in N+1.
  - JUMP in N+2; the CSR file has already registered the new mstatus/mepc.
  - IDLE in N+3; hold_o=0 from N+3.
- Each bus_busy_i cycle adds one cycle in WAIT_BUS before WRITE_CSR.
- Reset: state=IDLE; all outputs 0 except cause_o=RESET_CAUSE. Takes effect at the next edge, including mid-sequence; an aborted trap causes no CSR write.
- Back-to-back traps: at least 3 cycles apart. The interrupt handler entry sees MIE=0, so a held level irq does not re-trap until software re-enables it.
- Simultaneous ext+timer: ext taken; timer remains pending.

## Test plan
- Enable ext irq: mstatus=0x8, mie=0x800, mtvec=0x100, pc=0x40, irq_ext_i=1, bus idle.
  - Cycle N: hold_o=1.
  - N+1: csr_we_o=1, mstatus_o=0x80, mepc_o=0x40.
  - N+2: jump_o=1, jump_addr_o=0x100; cause_o=0x8000000B.
- mret: mstatus=0x80, mepc=0x44.
  - mstatus_o=0x88.
  - jump_addr_o=0x44 two cycles after detect; cause_o unchanged.
- Masked interrupts:
  - MIE=0 with irq_ext_i=1 and irq_timer_i=1 for 10 cycles → hold_o, csr_we_o, jump_o stay 0.
  - Then set MIE=1, mie=0x80 → timer trap taken, cause 0x80000007.
- ecall while bus_busy_i=1 for 3 cycles: hold_o for 6 cycles total, WRITE_CSR only after busy drops, cause_o=11, mtvec=0x103 → jump_addr_o=0x100.
- Simultaneous ecall and ext irq with both enabled: ecall taken (cause 11).
- rst_n=0 in WRITE_CSR cycle's following edge (during JUMP) and during WAIT_BUS: next cycle all outputs 0, state IDLE, no jump issued.

Source files
------------

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Trap and interrupt controller placed directly in front of the CSR file.
// It watches the execute stage for ecall/mret and for the two level-sensitive
// machine interrupts (external, timer). When it takes one of them it holds the
// whole pipeline, performs a single-cycle control write of mstatus/mepc into
// the CSR file and then redirects the PC to the trap vector or back to mepc.
//
// Sequence for an accepted event (bus idle):
//   N   : IDLE, event detected, hold_o=1, instruction is not committed
//   N+1 : WRITE_CSR, csr_we_o=csr_ctrl_we_o=1 with new mstatus/mepc/mie
//   N+2 : JUMP, jump_o=1 with jump_addr_o
//   N+3 : IDLE again, hold_o released
// An outstanding load/store inserts WAIT_BUS cycles between IDLE and WRITE_CSR.
//
// Parameters
//   RESET_CAUSE   reset value of cause_o
//
// Ports
//   clk            clock
//   rst_n          synchronous active-low reset
//   irq_ext_i      external interrupt request (level)
//   irq_timer_i    timer interrupt request (level)
//   ecall_i        ecall in execute stage, qualified by inst_valid_i
//   mret_i         mret in execute stage, qualified by inst_valid_i
//   inst_valid_i   execute stage holds a real instruction
//   inst_addr_i    PC of the execute-stage instruction
//   bus_busy_i     load/store transaction outstanding
//   mstatus_i      current mstatus from CSR file
//   mepc_i         current mepc from CSR file
//   mtvec_i        current mtvec from CSR file
//   mie_i          current mie from CSR file
//   hold_o         stall the whole pipeline
//   jump_o         one-cycle PC redirect + flush
//   jump_addr_o    redirect target
//   csr_we_o       CSR write enable
//   csr_ctrl_we_o  select control-write values in the CSR file
//   mstatus_o      mstatus value for the control write
//   mepc_o         mepc value for the control write
//   mie_o          mie value for the control write
//   cause_o        cause of the last trap taken (feeds mcause later)
// -----------------------------------------------------------------------------
module trap_ctrl #(
   parameter logic [31:0] RESET_CAUSE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq_ext_i,
   input  logic        irq_timer_i,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_addr_i,
   input  logic        bus_busy_i,
   input  logic [31:0] mstatus_i,
   input  logic [31:0] mepc_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mie_i,
   output logic        hold_o,
   output logic        jump_o,
   output logic [31:0] jump_addr_o,
   output logic        csr_we_o,
   output logic        csr_ctrl_we_o,
   output logic [31:0] mstatus_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mie_o,
   output logic [31:0] cause_o
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam logic [31:0] CAUSE_ECALL = 32'd11;
   localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
   localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

   // Bit positions inside mstatus / mie
   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;

   // Vector base is word aligned; the low two bits are the mode field.
   localparam logic [31:0] MTVEC_BASE_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_BUS  = 2'b01,
      ST_WRITE_CSR = 2'b10,
      ST_JUMP      = 2'b11
   } state_e;

   // ---------------------------------------------------------------------------
   // mstatus transforms
   // ---------------------------------------------------------------------------
   // Trap entry: save MIE into MPIE and disable interrupts, so the handler
   // starts with MIE=0 and a still-asserted level irq cannot re-trap at once.
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE]  = 1'b0;
      return r;
   endfunction

   // Trap return: restore MIE from MPIE and set MPIE.
   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
      logic [31:0] r;
      r               = ms;
      r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // State and latched event context
   // ---------------------------------------------------------------------------
   state_e      state_q,      state_d;
   logic        is_mret_q,    is_mret_d;    // 1: sequence is an mret, 0: a trap
   logic [31:0] epc_q,        epc_d;        // PC of the interrupted instruction
   logic [31:0] trap_cause_q, trap_cause_d; // cause pending for cause_o
   logic [31:0] cause_q,      cause_d;

   // ---------------------------------------------------------------------------
   // Event detection (only meaningful in IDLE)
   // ---------------------------------------------------------------------------
   logic mret_ev_s;
   logic ecall_ev_s;
   logic ext_ev_s;
   logic timer_ev_s;
   logic accept_s;

   assign mret_ev_s  = inst_valid_i & mret_i;
   assign ecall_ev_s = inst_valid_i & ecall_i;
   assign ext_ev_s   = inst_valid_i & irq_ext_i & mstatus_i[MSTATUS_MIE]
                       & mie_i[MIE_MEIE];
   assign timer_ev_s = inst_valid_i & irq_timer_i & mstatus_i[MSTATUS_MIE]
                       & mie_i[MIE_MTIE];
   assign accept_s   = mret_ev_s | ecall_ev_s | ext_ev_s | timer_ev_s;

   // Next-state logic and latching of the event context
   always_comb begin
      state_d      = state_q;
      is_mret_d    = is_mret_q;
      epc_d        = epc_q;
      trap_cause_d = trap_cause_q;
      cause_d      = cause_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               is_mret_d = mret_ev_s;
               epc_d     = inst_addr_i;
               // Priority mret > ecall > ext > timer; mret keeps the old cause.
               if (mret_ev_s) begin
                  trap_cause_d = trap_cause_q;
               end else if (ecall_ev_s) begin
                  trap_cause_d = CAUSE_ECALL;
               end else if (ext_ev_s) begin
                  trap_cause_d = CAUSE_EXT;
               end else begin
                  trap_cause_d = CAUSE_TIMER;
               end
               state_d = bus_busy_i ? ST_WAIT_BUS : ST_WRITE_CSR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_BUS: begin
            if (bus_busy_i) begin
               state_d = ST_WAIT_BUS;
            end else begin
               state_d = ST_WRITE_CSR;
            end
         end
         ST_WRITE_CSR: begin
            state_d = ST_JUMP;
         end
         ST_JUMP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // WRITE_CSR lasts a single cycle and is only reached from IDLE or
      // WAIT_BUS, so state_d==WRITE_CSR marks the entry edge.
      if ((state_d == ST_WRITE_CSR) && !is_mret_d) begin
         cause_d = trap_cause_d;
      end else begin
         cause_d = cause_q;
      end
   end

   // State and context registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         is_mret_q    <= 1'b0;
         epc_q        <= 32'h0000_0000;
         trap_cause_q <= 32'h0000_0000;
         cause_q      <= RESET_CAUSE;
      end else begin
         state_q      <= state_d;
         is_mret_q    <= is_mret_d;
         epc_q        <= epc_d;
         trap_cause_q <= trap_cause_d;
         cause_q      <= cause_d;
      end
   end

   // Output decode from the state register
   always_comb begin
      hold_o        = 1'b0;
      jump_o        = 1'b0;
      jump_addr_o   = 32'h0000_0000;
      csr_we_o      = 1'b0;
      csr_ctrl_we_o = 1'b0;
      mstatus_o     = 32'h0000_0000;
      mepc_o        = 32'h0000_0000;
      mie_o         = 32'h0000_0000;

      case (state_q)
         ST_IDLE: begin
            // Stall in the detect cycle so the instruction is not committed;
            // suppressed while reset is asserted so reset shows all-zero.
            hold_o = accept_s & rst_n;
         end
         ST_WAIT_BUS: begin
            hold_o = 1'b1;
         end
         ST_WRITE_CSR: begin
            hold_o        = 1'b1;
            csr_we_o      = 1'b1;
            csr_ctrl_we_o = 1'b1;
            mie_o         = mie_i;
            if (is_mret_q) begin
               mstatus_o = mstatus_on_mret(mstatus_i);
               mepc_o    = mepc_i;
            end else begin
               mstatus_o = mstatus_on_trap(mstatus_i);
               mepc_o    = epc_q;
            end
         end
         ST_JUMP: begin
            hold_o = 1'b1;
            jump_o = 1'b1;
            // mepc_i already reflects any write made in WRITE_CSR.
            if (is_mret_q) begin
               jump_addr_o = mepc_i;
            end else begin
               jump_addr_o = mtvec_i & MTVEC_BASE_MASK;
            end
         end
         default: begin
            hold_o = 1'b0;
         end
      endcase
   end

   assign cause_o = cause_q;

endmodule
